sweep_stim_capture: RTL and testbench

- Synthesizable upstream/downstream companion to the exhaustive-vector benches of the Benchmark_testing suites.
- Walks an N_W-bit input vector through all 2^N_W values in ascending order and drives it into the DUT under test.
- Waits a programmable settle time, then samples the DUT's single-bit output.
- Emits ordered (vector, response) records through a small FIFO with a valid/ready handshake to a logger or signature stage.

---
 rtl/sweep_pkg.sv | 28 ++
 rtl/sweep_rec_fifo.sv | 69 ++++++
 rtl/sweep_stim_capture.sv | 158 +++++++++++++++
 tb/tb_sweep_stim_capture.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
//   Shared types for the exhaustive sweep stimulus/capture block.
//   - sweep_state_e : sequencer states (idle, settle wait, capture, drain, done)
//   - sweep_rec_t   : (vector, response, last) record at the default widths.
//                     The sweep top builds the same layout at its own
//                     parameterised widths and hands that type to the FIFO.
// -----------------------------------------------------------------------------
package sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } sweep_state_e;

  localparam int unsigned SWEEP_N_W   = 5;
  localparam int unsigned SWEEP_OUT_W = 1;

  typedef struct packed {
    logic [SWEEP_N_W-1:0]   vec;
    logic [SWEEP_OUT_W-1:0] resp;
    logic                   last;
  } sweep_rec_t;

endpackage

// File: rtl/sweep_rec_fifo.sv
// -----------------------------------------------------------------------------
// sweep_rec_fifo
//   Synchronous first-word-fall-through FIFO of sweep records.
//   A push while full is accepted when a pop happens in the same cycle.
//   Ports:
//     CK        in   clock, rising edge
//     reset     in   synchronous active-low reset (flushes the FIFO)
//     push      in   write request
//     push_data in   record to write
//     pop       in   read request (ignored when empty)
//     head      out  head record, all-zero when empty
//     full      out  DEPTH entries held
//     empty     out  no entries held
// -----------------------------------------------------------------------------
module sweep_rec_fifo
  import sweep_pkg::*;
#(
  parameter type         rec_t = sweep_rec_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic CK,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; validity comes from the pointers,
  // and leaving it unreset lets it map onto plain RAM/flops without reset.
  always_ff @(posedge CK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Present zeros while empty so the record fields are clean out of reset.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/sweep_stim_capture.sv
// -----------------------------------------------------------------------------
// sweep_stim_capture
//   Walks an N_W-bit stimulus through 0 .. 2^N_W-1, waits SETTLE cycles after
//   each change, samples the DUT response and queues (vector, response, last)
//   records in a FWFT FIFO with a valid/ready interface.
//   Ports:
//     CK          in   clock, rising edge
//     reset       in   synchronous active-low reset
//     start       in   begin a sweep (only honoured when idle)
//     busy        out  sweep in progress (settle/capture/drain/done)
//     done        out  one-cycle pulse after the final record was accepted
//     stim_o      out  vector applied to the DUT
//     dut_resp_i  in   DUT response
//     rec_valid   out  head record valid
//     rec_ready   in   downstream accepts head record
//     rec_vec     out  head record vector
//     rec_resp    out  head record response
//     rec_last    out  head record is the all-ones vector
//     ones_cnt    out  number of captured responses with bit 0 set
// -----------------------------------------------------------------------------
module sweep_stim_capture
  import sweep_pkg::*;
#(
  parameter int unsigned N_W        = 5,
  parameter int unsigned OUT_W      = 1,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   stim_o,
  input  logic [OUT_W-1:0] dut_resp_i,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_W-1:0]   rec_vec,
  output logic [OUT_W-1:0] rec_resp,
  output logic             rec_last,
  output logic [N_W:0]     ones_cnt
);

  localparam int unsigned    CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  typedef struct packed {
    logic [N_W-1:0]   vec;
    logic [OUT_W-1:0] resp;
    logic             last;
  } rec_t;

  sweep_state_e     state_q, state_d;
  logic [N_W-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W:0]     ones_q, ones_d;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic can_push;
  logic last_vec;
  rec_t push_rec;
  rec_t head_rec;

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  // A full FIFO that pops this cycle still has room for the capture.
  assign can_push  = !fifo_full || pop;
  assign last_vec  = &stim_q;
  assign push_rec  = '{vec: stim_q, resp: dut_resp_i, last: last_vec};

  always_ff @(posedge CK) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          stim_d  = '0;
          ones_d  = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Counter is loaded with SETTLE-1, so this state lasts SETTLE cycles.
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        // Without room the sample is simply retried next cycle.
        if (can_push) begin
          push   = 1'b1;
          ones_d = ones_q + {{N_W{1'b0}}, dut_resp_i[0]};
          if (last_vec) begin
            state_d = ST_DRAIN;
          end else begin
            stim_d  = stim_q + N_W'(1);
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  sweep_rec_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CK        (CK),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign stim_o   = stim_q;
  assign ones_cnt = ones_q;
  assign rec_vec  = head_rec.vec;
  assign rec_resp = head_rec.resp;
  assign rec_last = head_rec.last;

endmodule

// File: tb/tb_sweep_stim_capture.sv
// -----------------------------------------------------------------------------
// tb_sweep_stim_capture
//   Two instances share clock and reset:
//     u_dut_a : defaults (SETTLE=1), response = XOR parity of the stimulus
//     u_dut_b : SETTLE=3, response = stim_o[0] delayed two cycles
//   A compare process holds a record-level model (the next vector each stream
//   must deliver and its response function) and checks every valid head,
//   every done pulse and the vector spacing of the slow instance. Directed
//   sequences add literal expectations for stalls, restarts and reset.
// -----------------------------------------------------------------------------
module tb_sweep_stim_capture;

  localparam int NV = 32;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic reset;

  logic       start_a, busy_a, done_a, valid_a, ready_a, last_a;
  logic [4:0] stim_a, vec_a;
  logic [0:0] resp_a, rresp_a;
  logic [5:0] ones_a;

  logic       start_b, busy_b, done_b, valid_b, ready_b, last_b;
  logic [4:0] stim_b, vec_b;
  logic [0:0] resp_b, rresp_b;
  logic [5:0] ones_b;
  logic       d1_b, d2_b;

  assign resp_a = ^stim_a;

  always @(posedge CK) begin
    d1_b <= stim_b[0];
    d2_b <= d1_b;
  end
  assign resp_b = d2_b;

  sweep_stim_capture u_dut_a (
    .CK (CK), .reset (reset), .start (start_a), .busy (busy_a), .done (done_a),
    .stim_o (stim_a), .dut_resp_i (resp_a), .rec_valid (valid_a),
    .rec_ready (ready_a), .rec_vec (vec_a), .rec_resp (rresp_a),
    .rec_last (last_a), .ones_cnt (ones_a)
  );

  sweep_stim_capture #(.SETTLE(3)) u_dut_b (
    .CK (CK), .reset (reset), .start (start_b), .busy (busy_b), .done (done_b),
    .stim_o (stim_b), .dut_resp_i (resp_b), .rec_valid (valid_b),
    .rec_ready (ready_b), .rec_vec (vec_b), .rec_resp (rresp_b),
    .rec_last (last_b), .ones_cnt (ones_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response each stream must report for a vector.
  function automatic logic f_a(input logic [4:0] v);
    return ^v;
  endfunction

  function automatic logic f_b(input logic [4:0] v);
    return v[0];
  endfunction

  function automatic int model_ones(input bit sel_b);
    int n = 0;
    for (int v = 0; v < NV; v++) n += sel_b ? int'(f_b(5'(v))) : int'(f_a(5'(v)));
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process (negative edge, away from the active edge)
  // ---------------------------------------------------------------------------
  int         exp_a = 0, exp_b = 0;
  int         done_cnt_a = 0, done_cnt_b = 0;
  int         cyc = 0, cap_age_a = 0, last_chg_b = 0;
  bit         prev_done_a = 0, prev_done_b = 0, cap_seen_a = 0, have_chg_b = 0;
  logic [4:0] prev_stim_b = '0;
  logic [5:0] prev_ones_a = '0;

  initial begin
    forever begin
      @(negedge CK);
      cyc++;
      if (reset !== 1'b1) begin
        exp_a = 0; exp_b = 0;
        prev_done_a = 0; prev_done_b = 0;
        cap_seen_a = 0; have_chg_b = 0;
        prev_stim_b = '0; prev_ones_a = '0;
      end else begin
        // ---- stream A ----
        if (valid_a) begin
          check("a_rec_vec",  vec_a,   exp_a);
          check("a_rec_resp", rresp_a, f_a(5'(exp_a)));
          check("a_rec_last", last_a,  exp_a == NV - 1);
          if (ready_a) exp_a++;
        end
        if (stim_a == 5'd31 && busy_a && ones_a != prev_ones_a) begin
          cap_seen_a = 1; cap_age_a = 0;
        end else if (cap_seen_a) begin
          cap_age_a++;
        end
        if (prev_done_a) check("a_busy_after_done", busy_a, 0);
        if (done_a) begin
          done_cnt_a++;
          check("a_done_all_records", exp_a, NV);
          check("a_done_ones", ones_a, model_ones(0));
          check("a_done_latency_le3", cap_seen_a && cap_age_a <= 3, 1);
          exp_a = 0; cap_seen_a = 0;
        end
        prev_done_a = done_a;
        prev_ones_a = ones_a;

        // ---- stream B ----
        if (valid_b) begin
          check("b_rec_vec",  vec_b,   exp_b);
          check("b_rec_resp", rresp_b, f_b(5'(exp_b)));
          check("b_rec_last", last_b,  exp_b == NV - 1);
          if (ready_b) exp_b++;
        end
        if (busy_b && stim_b != prev_stim_b) begin
          if (have_chg_b) check("b_vector_period", cyc - last_chg_b, 4);
          have_chg_b = 1; last_chg_b = cyc;
        end
        prev_stim_b = stim_b;
        if (prev_done_b) check("b_busy_after_done", busy_b, 0);
        if (done_b) begin
          done_cnt_b++;
          check("b_done_all_records", exp_b, NV);
          check("b_done_ones", ones_b, model_ones(1));
          exp_b = 0; have_chg_b = 0;
        end
        prev_done_b = done_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_stim_a(input logic [4:0] v, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (stim_a == v) hit = 1;
    end
    check("a_wait_stim", stim_a, v);
  endtask

  task automatic wait_done_a(input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (done_a) hit = 1;
    end
    check("a_wait_done", done_a, 1);
  endtask

  task automatic wait_done_b(input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (done_b) hit = 1;
    end
    check("b_wait_done", done_b, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_a_stim",  stim_a,  0);
    check("rst_a_valid", valid_a, 0);
    check("rst_a_vec",   vec_a,   0);
    check("rst_a_resp",  rresp_a, 0);
    check("rst_a_last",  last_a,  0);
    check("rst_a_busy",  busy_a,  0);
    check("rst_a_done",  done_a,  0);
    check("rst_a_ones",  ones_a,  0);
    check("rst_b_valid", valid_b, 0);
    check("rst_b_busy",  busy_b,  0);
    reset = 1'b1;
    tick();

    // Full sweep with a start re-pulse while busy at vector 10
    pulse_start_a();
    check("a_busy_after_start", busy_a, 1);
    check("a_first_stim", stim_a, 0);
    wait_stim_a(5'd10, 100);
    pulse_start_a();
    check("a_mid_start_ignored", stim_a, 10);
    wait_done_a(200);
    tick();
    check("a_idle_after_done", busy_a, 0);
    repeat (3) tick();
    check("a_ones_hold", ones_a, 16);
    check("a_done_count_1", done_cnt_a, 1);

    // Second sweep under backpressure: rec_ready low for the first 20 cycles
    ready_a = 1'b0;
    pulse_start_a();
    check("a_ones_cleared", ones_a, 0);
    check("a_restart_stim", stim_a, 0);
    repeat (19) tick();
    check("a_stall_stim", stim_a, 4);
    check("a_stall_valid", valid_a, 1);
    check("a_stall_head", vec_a, 0);
    // Full FIFO, capture pending, pop and push in the same cycle
    ready_a = 1'b1;
    tick();
    check("a_fullpp_stim", stim_a, 5);
    check("a_fullpp_head", vec_a, 1);
    // Occupancy stayed at 4: with no pops the next capture must stall
    ready_a = 1'b0;
    repeat (6) tick();
    check("a_fullpp_occupancy", stim_a, 5);
    check("a_fullpp_head_hold", vec_a, 1);
    ready_a = 1'b1;
    wait_done_a(300);
    tick();
    check("a_done_count_2", done_cnt_a, 2);

    // Slow instance, SETTLE=3
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy_after_start", busy_b, 1);
    wait_done_b(400);
    tick();
    check("b_done_count", done_cnt_b, 1);

    // Reset mid-sweep: stim_o=17 with records 15 and 16 queued
    ready_a = 1'b1;
    pulse_start_a();
    wait_stim_a(5'd16, 100);
    ready_a = 1'b0;
    tick();
    tick();
    check("a_prerst_stim", stim_a, 17);
    check("a_prerst_head", vec_a, 15);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("a_postrst_stim",  stim_a,  0);
    check("a_postrst_valid", valid_a, 0);
    check("a_postrst_busy",  busy_a,  0);
    check("a_postrst_ones",  ones_a,  0);
    ready_a = 1'b1;
    repeat (10) tick();
    check("a_postrst_idle", busy_a, 0);
    check("a_no_done_on_reset", done_cnt_a, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
